// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline sequencing controller.
// Ports: none (package only).
// Holds the controller state encoding, the hardwired-zero register id and
// the bounds of the data-memory freeze counter.
package mips_pipe_pkg;

  // RUN: normal issue; MEMWAIT: pipeline frozen on a data-memory access.
  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_e;

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Largest legal data-memory latency and the width of its down-counter.
  localparam int MEM_LAT_MAX = 15;
  localparam int MEM_CNT_W   = 4;

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating event counter used for pipeline performance statistics.
// Ports: clk, rst_n (async active-low), inc (count enable), cnt (value).
// Latency: cnt reflects an increment on the clock edge after inc is high;
// the value sticks at all-ones instead of wrapping.
module mips_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath: load-use
// stalls, EX-resolved branch/jump redirects and data-memory freezes.
// Ports: clk, rst_n; ID register fields (id_rs/id_rt/id_use_*); ID/EX
// control outputs (ex_*); EX/MEM mem_access; per-register write enables,
// flush/bubble/redirect controls, mem_ready; stall_cnt and flush_cnt.
// All controls are combinational (same-cycle response); only the freeze
// counter and the statistics counters are registered.
module mips_pipe_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_MemRead,
  input  logic             ex_RegWrite,
  input  logic [4:0]       ex_WriteRegister,
  input  logic             ex_Branch,
  input  logic             ex_Zero,
  input  logic             ex_Jump,
  input  logic             mem_access,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             pc_redirect,
  output logic             mem_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Latency outside the legal range is clamped so the 4-bit counter holds it.
  localparam int LAT_C = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                         (MEM_LAT < 0)           ? 0 : MEM_LAT;
  localparam logic [MEM_CNT_W-1:0] LAT = MEM_CNT_W'(LAT_C);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [MEM_CNT_W-1:0] r_cnt;
  logic [MEM_CNT_W-1:0] w_cnt_nxt;

  logic w_redirect;
  logic w_load_use;
  logic w_frozen;
  logic w_release;

  // ---------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------
  assign w_redirect = ex_Jump | (ex_Branch & ex_Zero);

  // Only a load in EX whose result lands in a real register the ID
  // instruction actually reads forces a stall.
  assign w_load_use = ex_MemRead & ex_RegWrite &
                      (ex_WriteRegister != REG_ZERO) &
                      ((id_use_rs & (id_rs == ex_WriteRegister)) |
                       (id_use_rt & (id_rt == ex_WriteRegister)));

  // In RUN a new access freezes immediately; in MEMWAIT the last counted
  // cycle (cnt == 1) is the release cycle, so the freeze lasts MEM_LAT.
  assign w_release = (r_state == MEMWAIT) && (r_cnt == MEM_CNT_W'(1));
  assign w_frozen  = (r_state == RUN) ? (mem_access && (LAT != '0))
                                      : !w_release;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_frozen) begin
          w_state_nxt = MEMWAIT;
          w_cnt_nxt   = LAT;
        end
      end
      MEMWAIT: begin
        if (w_release) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline controls
  // ---------------------------------------------------------------------
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_bubble = 1'b0;
    exmem_write = 1'b0;
    pc_redirect = 1'b0;
    mem_ready   = 1'b0;
    // Everything is held low in reset and while frozen; hazards seen during
    // a freeze are simply re-evaluated once the release cycle arrives.
    if (rst_n && !w_frozen) begin
      mem_ready   = w_release;
      exmem_write = 1'b1;
      idex_write  = 1'b1;
      if (w_redirect) begin
        // The ID instruction is on the wrong path, so a coincident
        // load-use hazard is irrelevant: squash both IF/ID and ID/EX.
        pc_write    = 1'b1;
        pc_redirect = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (w_load_use) begin
        // Hold PC and IF/ID; the bubble in ID/EX clears the hazard next cycle.
        idex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------
  mips_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write),
    .cnt   (stall_cnt)
  );

  mips_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_redirect),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Self-checking bench for mips_pipe_ctrl.
// Instance A: MEM_LAT=2, CNT_W=16 (hazards, freezes, reset mid-freeze).
// Instance B: MEM_LAT=0, CNT_W=4 (no freezing, stall counter saturation).
module tb_mips_pipe_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mrd;
    logic       rw;
    logic [4:0] wr;
    logic       br;
    logic       zr;
    logic       jp;
    logic       ma;
  } in_t;

  typedef struct {
    string       nm;
    bit          sel;
    logic [7:0]  ctl;
    logic [15:0] s;
    logic [15:0] f;
  } exp_t;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
  //  exmem_write, pc_redirect, mem_ready}
  localparam logic [7:0] C_NONE = 8'hD4;
  localparam logic [7:0] C_LU   = 8'h1C;
  localparam logic [7:0] C_RD   = 8'hFE;
  localparam logic [7:0] C_FRZ  = 8'h00;
  localparam logic [7:0] C_REL  = 8'hD5;
  localparam logic [7:0] C_RELU = 8'h1D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  a_in = '0;
  in_t  b_in = '0;

  logic        a_pc, a_ifw, a_iff, a_idw, a_idb, a_exw, a_rd, a_mr;
  logic [15:0] a_s, a_f;
  logic        b_pc, b_ifw, b_iff, b_idw, b_idb, b_exw, b_rd, b_mr;
  logic [3:0]  b_s, b_f;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mips_pipe_ctrl #(.MEM_LAT(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs(a_in.rs), .id_rt(a_in.rt), .id_use_rs(a_in.urs), .id_use_rt(a_in.urt),
    .ex_MemRead(a_in.mrd), .ex_RegWrite(a_in.rw), .ex_WriteRegister(a_in.wr),
    .ex_Branch(a_in.br), .ex_Zero(a_in.zr), .ex_Jump(a_in.jp), .mem_access(a_in.ma),
    .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_iff), .idex_write(a_idw),
    .idex_bubble(a_idb), .exmem_write(a_exw), .pc_redirect(a_rd), .mem_ready(a_mr),
    .stall_cnt(a_s), .flush_cnt(a_f)
  );

  mips_pipe_ctrl #(.MEM_LAT(0), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs(b_in.rs), .id_rt(b_in.rt), .id_use_rs(b_in.urs), .id_use_rt(b_in.urt),
    .ex_MemRead(b_in.mrd), .ex_RegWrite(b_in.rw), .ex_WriteRegister(b_in.wr),
    .ex_Branch(b_in.br), .ex_Zero(b_in.zr), .ex_Jump(b_in.jp), .mem_access(b_in.ma),
    .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_iff), .idex_write(b_idw),
    .idex_bubble(b_idb), .exmem_write(b_exw), .pc_redirect(b_rd), .mem_ready(b_mr),
    .stall_cnt(b_s), .flush_cnt(b_f)
  );

  function automatic in_t mk(int rs, int rt, bit urs, bit urt, bit mrd, bit rw,
                             int wr, bit br, bit zr, bit jp, bit ma);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt;
    v.mrd = mrd; v.rw = rw; v.wr = 5'(wr);
    v.br = br; v.zr = zr; v.jp = jp; v.ma = ma;
    return v;
  endfunction

  // Drive one cycle of stimulus and queue its hand-computed response.
  task automatic step(input string nm, input bit sel, input bit rst, input in_t v,
                      input logic [7:0] ctl, input int s, input int f);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    if (sel) begin a_in = '0; b_in = v; end
    else     begin a_in = v;  b_in = '0; end
    e.nm = nm; e.sel = sel; e.ctl = ctl; e.s = 16'(s); e.f = 16'(f);
    q.push_back(e);
  endtask

  // Monitor: every cycle has a response; compare away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0]  act;
      logic [15:0] as, af;
      e = q.pop_front();
      if (e.sel) begin
        act = {b_pc, b_ifw, b_iff, b_idw, b_idb, b_exw, b_rd, b_mr};
        as = {12'd0, b_s}; af = {12'd0, b_f};
      end else begin
        act = {a_pc, a_ifw, a_iff, a_idw, a_idb, a_exw, a_rd, a_mr};
        as = a_s; af = a_f;
      end
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL %s ctl: got %h want %h", e.nm, act, e.ctl);
      end
      total++;
      if (as !== e.s) begin
        bad++;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, as, e.s);
      end
      total++;
      if (af !== e.f) begin
        bad++;
        $display("FAIL %s flush_cnt: got %0d want %0d", e.nm, af, e.f);
      end
    end
  end

  initial begin : stim
    in_t idle, lu8, lu_rt9, ma1;
    int  waited;
    idle   = '0;
    lu8    = mk(8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0);
    lu_rt9 = mk(0, 9, 0, 1, 1, 1, 9, 0, 0, 0, 0);
    ma1    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // ---- instance A: MEM_LAT=2 ----
    step("reset",        0, 0, idle, C_FRZ, 0, 0);
    step("run_idle",     0, 1, idle, C_NONE, 0, 0);
    step("load_use_rs",  0, 1, lu8, C_LU, 0, 0);
    step("after_bubble", 0, 1, idle, C_NONE, 1, 0);
    step("reg0_nostall", 0, 1, mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), C_NONE, 1, 0);
    step("rt_unused",    0, 1, mk(0, 9, 0, 0, 1, 1, 9, 0, 0, 0, 0), C_NONE, 1, 0);
    step("load_use_rt",  0, 1, lu_rt9, C_LU, 1, 0);
    step("br_over_lu",   0, 1, mk(8, 0, 1, 0, 1, 1, 8, 1, 1, 0, 0), C_RD, 2, 0);
    step("after_redir",  0, 1, idle, C_NONE, 2, 1);
    step("br_not_taken", 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_NONE, 2, 1);
    step("jump",         0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_RD, 2, 1);
    step("frz1_a",       0, 1, ma1, C_FRZ, 2, 2);
    step("frz1_b_redir", 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_FRZ, 3, 2);
    step("release1",     0, 1, ma1, C_REL, 4, 2);
    step("frz2_a",       0, 1, ma1, C_FRZ, 4, 2);
    step("frz2_b",       0, 1, ma1, C_FRZ, 5, 2);
    step("release2_lu",  0, 1, lu8, C_RELU, 6, 2);
    step("post_release", 0, 1, idle, C_NONE, 7, 2);
    step("frz3_a",       0, 1, ma1, C_FRZ, 7, 2);
    step("rst_midfreeze", 0, 0, ma1, C_FRZ, 0, 0);
    step("restart_a",    0, 1, ma1, C_FRZ, 0, 0);
    step("restart_b",    0, 1, ma1, C_FRZ, 1, 0);
    step("restart_rel",  0, 1, idle, C_REL, 2, 0);
    step("restart_run",  0, 1, idle, C_NONE, 2, 0);

    // ---- instance B: MEM_LAT=0, CNT_W=4 ----
    step("zl_mem",       1, 1, ma1, C_NONE, 0, 0);
    step("zl_mem2",      1, 1, ma1, C_NONE, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step($sformatf("sat_%0d", k), 1, 1, lu8 | ma1, C_LU, (k - 1 > 15) ? 15 : k - 1, 0);
    end
    step("sat_hold",     1, 1, idle, C_NONE, 15, 0);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_pipe_ctrl.md
Name: mips_pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Generates write-enable, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Covers three cases: load-use hazards, taken branch/jump redirects resolved in EX, and a fixed-latency data memory that freezes the whole pipeline.
- Sits beside the datapath. Its inputs are the ID-stage register fields, the outputs of the ID/EX register, and the EX/MEM memory-access flags.

Parameters:
- MEM_LAT, 2, data-memory freeze cycles per load/store in MEM; legal range 0..15; 0 disables freezing.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_MemRead  in  1  out_MemRead of ID/EX.
- ex_RegWrite  in  1  out_RegWrite of ID/EX.
- ex_WriteRegister  in  5  out_WriteRegister of ID/EX.
- ex_Branch  in  1  out_Branch of ID/EX.
- ex_Zero  in  1  ALU zero flag in EX.
- ex_Jump  in  1  out_Jump of ID/EX.
- mem_access  in  1  EX/MEM MemRead | MemWrite.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_write  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads all control bits as 0.
- exmem_write  out  1  EX/MEM and MEM/WB load enable.
- pc_redirect  out  1  PC mux selects the branch/jump target.
- mem_ready  out  1  memory access completes this cycle.
- stall_cnt  out  CNT_W  cycles with pc_write=0.
- flush_cnt  out  CNT_W  redirect events.

Behaviour:
- Reset: while rst_n=0, state=RUN, wait counter=0, stall_cnt=0 and flush_cnt=0. All control outputs are 0 during reset, including all write enables.
- States: RUN and MEMWAIT. Outputs are combinational from state, counter and inputs. Zero added latency: hazard responses appear in the same cycle.
- Derived terms:
  - redirect = ex_Jump | (ex_Branch & ex_Zero).
  - load_use = ex_MemRead & ex_RegWrite & (ex_WriteRegister != 0) & ((id_use_rs & id_rs == ex_WriteRegister) | (id_use_rt & id_rt == ex_WriteRegister)).
  - freeze (RUN) = mem_access & (MEM_LAT != 0).
  - freeze (MEMWAIT) = (cnt != 1).
- Freeze (highest priority): every write enable is 0; ifid_flush, idex_bubble, pc_redirect and mem_ready are 0. The redirect and load-use terms are ignored while frozen and re-evaluated in the release cycle.
- RUN with freeze: load cnt <= MEM_LAT and go to MEMWAIT.
- MEMWAIT: cnt decrements each cycle. When cnt == 1, that cycle is the release cycle:
  - mem_ready=1 and exmem_write=1;
  - normal priority logic applies to the other outputs;
  - next state is RUN.
  - Total freeze per access is exactly MEM_LAT cycles.
  - Back-to-back accesses re-freeze on the next cycle.
- Otherwise, by priority:
  - redirect: pc_write=1, pc_redirect=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_write=1.
  - load_use: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, exmem_write=1. Exactly one bubble; the hazard clears next cycle because ID/EX then holds the bubble.
  - none: all write enables 1; flush and bubble 0.
- Redirect and load_use in the same cycle: redirect wins, because the ID instruction is on the wrong path.
- Register $0 never causes a stall.
- stall_cnt increments on each non-reset cycle with pc_write=0. flush_cnt increments on each cycle with pc_redirect=1. Both saturate at 2^CNT_W-1 and never wrap.
- rst_n asserted mid-freeze: immediately returns to RUN with cnt=0. The pending access restarts its full freeze after reset if mem_access is still high.

Decomposition:
- Package mips_pipe_pkg:
  - state enum {RUN, MEMWAIT};
  - REG_ZERO = 5'd0;
  - the MEM_LAT legal-range constant.
- Sub-module mips_sat_counter (parameter W; inputs clk, rst_n, inc; output cnt), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: ex_MemRead=1, ex_RegWrite=1, ex_WriteRegister=8, id_rs=8, id_use_rs=1 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1.
- Register $0 and unused operand:
  - ex_WriteRegister=0, id_rs=0, id_use_rs=1 -> no stall;
  - ex_WriteRegister=9, id_rt=9, id_use_rt=0 -> no stall.
- Redirect: ex_Branch=1, ex_Zero=1 together with a load_use condition -> pc_redirect=1, ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
- Memory freeze with MEM_LAT=2 -> all write enables 0 for 2 cycles, then a release cycle with mem_ready=1. A second access immediately after gives another 2-cycle freeze; stall_cnt=4.
- Zero latency: MEM_LAT=0 -> mem_access never freezes; state stays RUN.
- Reset mid-freeze, plus saturation:
  - rst_n pulsed low during MEMWAIT -> all outputs 0 and counters 0 asynchronously; the freeze restarts after release.
  - CNT_W=4 with a held stall -> stall_cnt sticks at 15.
